layer0_patch_scheduler: RTL and testbench

// - Sequences the layer-0 7x7 patch extractor and the downstream PE array for one conv layer.
// - Starts the extractor and walks every spatial block in raster order.
// - Replays each ready patch to the PE array once per filter group.
// - Advances the extractor only after the PE array has finished with the patch.
// - Sits between the layer controller (layer_start/layer_done) and the extractor/PE handshakes.

---
 rtl/layer0_patch_scheduler.sv | 165 ++++++++++++++++
 tb/tb_layer0_patch_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/layer0_patch_scheduler.sv
// rtl/layer0_patch_scheduler.sv - sequences layer-0 patch extractor and PE array over all blocks
// Optional stall watchdog: define LAYER0_SCHED_WATCHDOG_EN.
module layer0_patch_scheduler #(
  parameter int NUM_BLOCKS_X    = 8,
  parameter int NUM_BLOCKS_Y    = 8,
  parameter int FILTER_GROUPS   = 4,
  parameter int WATCHDOG_CYCLES = 4096,
  localparam int GW = (FILTER_GROUPS > 1) ? $clog2(FILTER_GROUPS) : 1,
  localparam int XW = (NUM_BLOCKS_X > 1) ? $clog2(NUM_BLOCKS_X) : 1,
  localparam int YW = (NUM_BLOCKS_Y > 1) ? $clog2(NUM_BLOCKS_Y) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          layer_start,
  output logic          layer_busy,
  output logic          layer_done,
  output logic          ext_start,
  output logic          ext_next,
  input  logic          ext_block_ready,
  input  logic          ext_complete,
  output logic          pe_start,
  output logic [GW-1:0] pe_group,
  input  logic          pe_done,
  output logic [XW-1:0] blk_x,
  output logic [YW-1:0] blk_y,
  output logic [15:0]   blocks_done,
  output logic          error
);

  localparam logic [GW-1:0] LAST_G = GW'(FILTER_GROUPS - 1);
  localparam logic [XW-1:0] LAST_X = XW'(NUM_BLOCKS_X - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(NUM_BLOCKS_Y - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_KICK, S_WAIT_BLOCK, S_ISSUE, S_WAIT_PE,
    S_ADVANCE, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [GW-1:0] r_pe_group;
  logic [XW-1:0] r_blk_x;
  logic [YW-1:0] r_blk_y;
  logic [15:0]   r_blocks_done;
  logic          w_last_group;
  logic          w_last_x;
  logic          w_last_block;
  logic          w_wd_expire;

  assign w_last_group = (r_pe_group == LAST_G);
  assign w_last_x     = (r_blk_x == LAST_X);
  assign w_last_block = w_last_x && (r_blk_y == LAST_Y);

`ifdef LAYER0_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WDW-1:0] r_wd_cnt;
  logic           w_waiting;

  assign w_waiting = (r_state == S_WAIT_BLOCK) || (r_state == S_WAIT_PE) || (r_state == S_DRAIN);

  // Count restarts on every state change so each wait gets the full budget.
  always_ff @(posedge clk) begin
    if (reset || (w_next_state != r_state)) begin
      r_wd_cnt <= '0;
    end else if (w_waiting) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_wd_expire = (r_wd_cnt == WDW'(WATCHDOG_CYCLES - 1));
  assign error       = (r_state == S_ERR);
`else
  assign w_wd_expire = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:       if (layer_start) w_next_state = S_KICK;
      // Extractor still in COMPLETE from the previous layer: hold start until it clears.
      S_KICK:       if (!ext_complete) w_next_state = S_WAIT_BLOCK;
      S_WAIT_BLOCK: begin
        if (ext_block_ready) w_next_state = S_ISSUE;
        else if (w_wd_expire) w_next_state = S_ERR;
      end
      S_ISSUE:      w_next_state = S_WAIT_PE;
      S_WAIT_PE: begin
        if (pe_done) w_next_state = w_last_group ? S_ADVANCE : S_ISSUE;
        else if (w_wd_expire) w_next_state = S_ERR;
      end
      S_ADVANCE:    w_next_state = w_last_block ? S_DRAIN : S_WAIT_BLOCK;
      S_DRAIN: begin
        if (ext_complete) w_next_state = S_DONE;
        else if (w_wd_expire) w_next_state = S_ERR;
      end
      S_DONE:       w_next_state = S_IDLE;
      S_ERR:        w_next_state = S_ERR;
      default:      w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pe_group    <= '0;
      r_blk_x       <= '0;
      r_blk_y       <= '0;
      r_blocks_done <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (layer_start) begin
            r_pe_group    <= '0;
            r_blk_x       <= '0;
            r_blk_y       <= '0;
            r_blocks_done <= '0;
          end
        end
        S_WAIT_PE: begin
          if (pe_done) begin
            if (w_last_group) begin
              r_pe_group <= '0;
              if (r_blocks_done != 16'hFFFF) r_blocks_done <= r_blocks_done + 16'd1;
            end else begin
              r_pe_group <= r_pe_group + 1'b1;
            end
          end
        end
        S_ADVANCE: begin
          if (!w_last_block) begin
            if (w_last_x) begin
              r_blk_x <= '0;
              r_blk_y <= r_blk_y + 1'b1;
            end else begin
              r_blk_x <= r_blk_x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    layer_busy = (r_state != S_IDLE) && (r_state != S_ERR);
    ext_start  = (r_state == S_KICK);
    ext_next   = (r_state == S_ADVANCE);
    pe_start   = (r_state == S_ISSUE);
    layer_done = (r_state == S_DONE);
  end

  assign pe_group    = r_pe_group;
  assign blk_x       = r_blk_x;
  assign blk_y       = r_blk_y;
  assign blocks_done = r_blocks_done;

endmodule

// File: tb/tb_layer0_patch_scheduler.sv
// tb/tb_layer0_patch_scheduler.sv - directed bench for layer0_patch_scheduler with extractor and PE models
`timescale 1ns/1ps
module tb_layer0_patch_scheduler;

`ifdef LAYER0_SCHED_WATCHDOG_EN
  localparam int WD_ON = 1;
`else
  localparam int WD_ON = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, layer_start, ext_block_ready, ext_complete, pe_done;
  logic        layer_busy, layer_done, ext_start, ext_next, pe_start, error;
  logic [1:0]  pe_group;
  logic [2:0]  blk_x, blk_y;
  logic [15:0] blocks_done;

  layer0_patch_scheduler #(
    .NUM_BLOCKS_X(8), .NUM_BLOCKS_Y(8), .FILTER_GROUPS(4), .WATCHDOG_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .layer_busy(layer_busy),
    .layer_done(layer_done), .ext_start(ext_start), .ext_next(ext_next),
    .ext_block_ready(ext_block_ready), .ext_complete(ext_complete), .pe_start(pe_start),
    .pe_group(pe_group), .pe_done(pe_done), .blk_x(blk_x), .blk_y(blk_y),
    .blocks_done(blocks_done), .error(error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc_no, cmp_cyc, done_cyc;
  int ex_run, ex_dly, ex_nexts, ex_cdly, ex_clr;
  int pe_cnt, pe_hold, pe_bogus, chk_on;
  int n_pe_start, n_ext_next, n_layer_done, n_ext_start;

  task automatic clear_models();
    ext_block_ready = 0; ext_complete = 0; pe_done = 0; layer_start = 0;
    ex_run = 0; ex_dly = 0; ex_nexts = 0; ex_cdly = 0; ex_clr = 0;
    pe_cnt = 0; pe_hold = 0; pe_bogus = 0;
  endtask

  task automatic clear_counts();
    n_pe_start = 0; n_ext_next = 0; n_layer_done = 0; n_ext_start = 0;
    cmp_cyc = -100; done_cyc = -1;
  endtask

  // One clock: sample outputs at the falling edge, step both models, drive inputs.
  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    layer_start = 0;
    pe_done = 0;
    if (layer_done) begin n_layer_done++; done_cyc = cyc_no; end
    if (ext_start) n_ext_start++;
    if (pe_cnt > 0) begin
      pe_cnt--;
      if (pe_cnt == 0 && pe_hold == 0) pe_done = 1;
    end
    if (pe_start) begin
      if (chk_on != 0) begin
        check_eq("pe_group", 32'(pe_group), n_pe_start % 4);
        if (n_pe_start % 4 == 0) begin
          check_eq("blk_x", 32'(blk_x), (n_pe_start / 4) % 8);
          check_eq("blk_y", 32'(blk_y), (n_pe_start / 4) / 8);
          check_eq("blocks_done_run", 32'(blocks_done), n_pe_start / 4);
        end
      end
      n_pe_start++;
      pe_cnt = 3;
      if (pe_bogus != 0) begin pe_done = 1; pe_bogus = 0; end
    end
    if (ext_next) begin
      n_ext_next++;
      ext_block_ready = 0;
      ex_nexts++;
      if (ex_nexts == 64) begin ex_run = 0; ex_cdly = 2; end
      else ex_dly = 2;
    end else if (ext_start) begin
      if (ext_complete) begin
        if (ex_clr != 0) begin
          ext_complete = 0; ex_clr = 0; ex_run = 1; ex_nexts = 0; ex_dly = 2;
        end else ex_clr = 1;
      end else if (ex_run == 0) begin
        ex_run = 1; ex_nexts = 0; ex_dly = 2;
      end
    end else if (ex_run != 0 && !ext_block_ready) begin
      ex_dly--;
      if (ex_dly == 0) ext_block_ready = 1;
    end else if (ex_cdly > 0) begin
      ex_cdly--;
      if (ex_cdly == 0) begin ext_complete = 1; cmp_cyc = cyc_no; end
    end
  endtask

  task automatic run_layer(input string name, input int exp_starts, input int hazards);
    int hz1_cyc, hz2_cyc;
    bit finished;
    hz1_cyc = -1; hz2_cyc = -1; finished = 0;
    clear_counts();
    chk_on = 1;
    layer_start = 1;
    for (int i = 0; i < 6000 && !finished; i++) begin
      cyc();
      if (hazards != 0) begin
        if (n_pe_start == 9 && hz1_cyc < 0 && pe_bogus == 0) begin pe_bogus = 1; hz1_cyc = 0; end
        if (hz1_cyc == 0 && n_pe_start == 10) hz1_cyc = cyc_no;
        else if (hz1_cyc > 0 && cyc_no == hz1_cyc + 1) begin
          check_eq("hz_pe_group_hold", 32'(pe_group), 1);
          check_eq("hz_no_reissue", 32'(pe_start), 0);
        end
        if (n_pe_start == 30 && hz2_cyc < 0) begin layer_start = 1; hz2_cyc = cyc_no; end
        else if (hz2_cyc > 0 && cyc_no == hz2_cyc + 1) begin
          check_eq("hz_ls_blk_x", 32'(blk_x), 7);
          check_eq("hz_ls_blk_y", 32'(blk_y), 0);
          check_eq("hz_ls_no_kick", 32'(ext_start), 0);
          check_eq("hz_ls_busy", 32'(layer_busy), 1);
        end
      end
      if (n_layer_done > 0) finished = 1;
    end
    check_eq({name, "_timeout"}, 32'(finished), 1);
    repeat (3) cyc();
    check_eq({name, "_ext_start_cycles"}, n_ext_start, exp_starts);
    check_eq({name, "_pe_starts"}, n_pe_start, 256);
    check_eq({name, "_ext_next"}, n_ext_next, 64);
    check_eq({name, "_blocks_done"}, 32'(blocks_done), 64);
    check_eq({name, "_layer_done_pulses"}, n_layer_done, 1);
    check_eq({name, "_done_latency"}, done_cyc - cmp_cyc, 1);
    check_eq({name, "_idle_busy"}, 32'(layer_busy), 0);
    check_eq({name, "_last_blk"}, {26'd0, blk_y, blk_x}, 6'o77);
  endtask

  initial begin
    cyc_no = 0; chk_on = 0;
    clear_models();
    clear_counts();
    reset = 1;
    repeat (2) cyc();
    check_eq("rst_outputs", {26'd0, layer_busy, layer_done, ext_start, ext_next, pe_start, error}, 0);
    check_eq("rst_counters", {11'd0, pe_group, blk_x, blk_y, blocks_done}, 0);
    reset = 0;
    cyc();

    run_layer("L1", 1, 0);
    run_layer("L2", 2, 1);

    // Abort while waiting on the PE for block 5.
    clear_counts();
    layer_start = 1;
    for (int i = 0; i < 2000 && n_pe_start < 21; i++) cyc();
    check_eq("rst_mid_reached", n_pe_start, 21);
    cyc();
    check_eq("rst_mid_pre_blk_x", 32'(blk_x), 5);
    reset = 1;
    cyc();
    check_eq("rst_mid_outputs", {26'd0, layer_busy, layer_done, ext_start, ext_next, pe_start, error}, 0);
    check_eq("rst_mid_counters", {11'd0, pe_group, blk_x, blk_y, blocks_done}, 0);
    clear_models();
    cyc();
    reset = 0;
    cyc();

    // PE never answers the first pass.
    clear_counts();
    pe_hold = 1;
    layer_start = 1;
    for (int i = 0; i < 200 && n_pe_start < 1; i++) cyc();
    check_eq("wd_first_issue", n_pe_start, 1);
    repeat (16) cyc();
    check_eq("wd_not_yet", 32'(error), 0);
    cyc();
    check_eq("wd_error", 32'(error), WD_ON);
    check_eq("wd_busy", 32'(layer_busy), 1 - WD_ON);
    pe_hold = 0;
    pe_cnt = 0;
    pe_done = 1;
    cyc();
    check_eq("wd_late_done_group", 32'(pe_group), 1 - WD_ON);
    check_eq("wd_error_sticky", 32'(error), WD_ON);

    reset = 1;
    clear_models();
    repeat (2) cyc();
    reset = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
